// File: rtl/uart_fifo_pkg.sv
// uart_fifo_pkg
// Shared constants and types for the UART 16550A TX/RX FIFOs.
//   FIFO_DEPTH  : number of entries held by one FIFO
//   FIFO_DATA_W : width of one entry (a UART character)
//   FIFO_PTR_W  : read/write pointer width, also the trigger-level width
//   FIFO_CNT_W  : occupancy counter width (one extra bit so "full" is representable)
//   fifo_data_t : one FIFO entry
package uart_fifo_pkg;

    localparam int FIFO_DEPTH  = 16;
    localparam int FIFO_DATA_W = 8;
    localparam int FIFO_PTR_W  = 4;
    localparam int FIFO_CNT_W  = 5;

    typedef logic [FIFO_DATA_W-1:0] fifo_data_t;

endpackage

// File: rtl/uart_fifo_if.sv
// uart_fifo_if
// Request/status bundle between a FIFO user and uart_fifo.
//   en           : FIFO enable; requests are ignored while low
//   push_in      : write request, din captured at the clock edge
//   pop_in       : read request, head entry discarded at the clock edge
//   din          : write data
//   threshold    : fill level at which thre_trigger asserts
//   dout         : head entry (first-word-fall-through)
//   empty / full : occupancy status
//   overrun      : one-cycle pulse after a push was rejected because the FIFO was full
//   underrun     : one-cycle pulse after a pop was rejected because the FIFO was empty
//   thre_trigger : occupancy >= threshold
// The master modport is the FIFO user, the slave modport is the FIFO itself.
interface uart_fifo_if
    import uart_fifo_pkg::*;
#(
    parameter int DATA_W = FIFO_DATA_W
) ();

    logic                  en;
    logic                  push_in;
    logic                  pop_in;
    logic [DATA_W-1:0]     din;
    logic [FIFO_PTR_W-1:0] threshold;
    logic [DATA_W-1:0]     dout;
    logic                  empty;
    logic                  full;
    logic                  overrun;
    logic                  underrun;
    logic                  thre_trigger;

    modport master (
        output en, push_in, pop_in, din, threshold,
        input  dout, empty, full, overrun, underrun, thre_trigger
    );

    modport slave (
        input  en, push_in, pop_in, din, threshold,
        output dout, empty, full, overrun, underrun, thre_trigger
    );

endinterface

// File: rtl/uart_fifo_mem.sv
// uart_fifo_mem
// Storage array for uart_fifo: synchronous write, asynchronous read.
// Contents are never reset; the control logic guarantees that only
// entries that were written are ever presented as valid data.
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : combinational read of the entry at raddr
module uart_fifo_mem #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [PTR_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [PTR_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Write port: one entry per clock when enabled.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port is purely combinational so the head entry falls through
    // to the output without waiting for a pop.
    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_fifo.sv
// uart_fifo
// 16-entry x 8-bit first-word-fall-through FIFO for the 16550A TX and RX
// paths, with overrun/underrun pulses and a programmable fill trigger.
//   clk : single clock, all state changes on the rising edge
//   rst : synchronous active-high reset (pointers, count and error pulses;
//         storage is left as is)
//   bus : uart_fifo_if slave modport carrying requests, data and status
module uart_fifo
    import uart_fifo_pkg::*;
#(
    parameter int DATA_W = FIFO_DATA_W,
    parameter int DEPTH  = FIFO_DEPTH
) (
    input  logic        clk,
    input  logic        rst,
    uart_fifo_if.slave  bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              overrun_q;
    logic              underrun_q;
    logic              is_full;
    logic              is_empty;
    logic              push_ok;
    logic              pop_ok;
    logic              push_reject;
    logic              pop_reject;
    logic [DATA_W-1:0] head;

    // Flags come straight from the counter so they track the state with
    // no extra latency.
    assign is_full  = (count == CNT_FULL);
    assign is_empty = (count == '0);

    // A push is still accepted when full if a pop frees the slot in the
    // same cycle. A pop on an empty FIFO is always refused, even alongside
    // a push, because the pushed byte is not yet in storage.
    assign push_ok     = bus.en & bus.push_in & (~is_full | bus.pop_in);
    assign pop_ok      = bus.en & bus.pop_in & ~is_empty;
    assign push_reject = bus.en & bus.push_in & is_full & ~bus.pop_in;
    assign pop_reject  = bus.en & bus.pop_in & is_empty;

    uart_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (push_ok),
        .waddr (wr_ptr),
        .wdata (bus.din),
        .raddr (rd_ptr),
        .rdata (head)
    );

    // Pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    // Occupancy only moves when exactly one of push/pop is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (push_ok && !pop_ok) begin
            count <= count + CNT_W'(1);
        end else if (pop_ok && !push_ok) begin
            count <= count - CNT_W'(1);
        end
    end

    // Error pulses are re-evaluated every cycle, so a repeated violation
    // keeps them high and a clean cycle drops them again.
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun_q  <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            overrun_q  <= push_reject;
            underrun_q <= pop_reject;
        end
    end

    assign bus.dout         = head;
    assign bus.empty        = is_empty;
    assign bus.full         = is_full;
    assign bus.overrun      = overrun_q;
    assign bus.underrun     = underrun_q;
    assign bus.thre_trigger = (count >= CNT_W'(bus.threshold));

endmodule

// File: tb/tb_uart_fifo.sv
// tb_uart_fifo
// Self-checking bench for uart_fifo: a table of hand-computed vectors,
// directed multi-cycle sequences, and randomized traffic compared against
// a queue-based reference model.
module tb_uart_fifo;

    logic clk;
    logic rst;

    uart_fifo_if bus ();

    uart_fifo dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something stalls the stimulus process.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    int nChecks     = 0;
    int nMiscompares = 0;

    // Reference model: the FIFO contents as a queue plus the two error pulses.
    logic [7:0] modelQ[$];
    bit         modelOvr;
    bit         modelUnd;
    logic [3:0] curThr;

    typedef struct {
        bit         rst;
        bit         en;
        bit         push;
        bit         pop;
        logic [7:0] din;
        logic [3:0] thr;
        bit         eEmpty;
        bit         eFull;
        bit         eOvr;
        bit         eUnd;
        bit         eThre;
        bit         chkDout;
        logic [7:0] eDout;
    } vec_t;

    vec_t vecs[12];

    task automatic checkBit(input string name, input logic got, input logic exp);
        nChecks++;
        if (got !== exp) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got %0b, expected %0b", name, got, exp);
        end
    endtask

    task automatic checkByte(input string name, input logic [7:0] got, input logic [7:0] exp);
        nChecks++;
        if (got !== exp) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got %02h, expected %02h", name, got, exp);
        end
    endtask

    // Drive one cycle of requests, let the edge happen, then advance the model.
    task automatic applyStimulus(input bit r, input bit e, input bit p, input bit o,
                                 input logic [7:0] d, input logic [3:0] thr);
        int  sz;
        bit  wasFull;
        bit  wasEmpty;
        bit  pushAcc;
        bit  popAcc;
        rst           = r;
        bus.en        = e;
        bus.push_in   = p;
        bus.pop_in    = o;
        bus.din       = d;
        bus.threshold = thr;
        curThr        = thr;
        @(posedge clk);
        #1;
        sz       = modelQ.size();
        wasFull  = (sz == 16);
        wasEmpty = (sz == 0);
        if (r) begin
            modelQ.delete();
            modelOvr = 1'b0;
            modelUnd = 1'b0;
        end else begin
            pushAcc  = e && p && (!wasFull || o);
            popAcc   = e && o && !wasEmpty;
            modelOvr = e && p && wasFull && !o;
            modelUnd = e && o && wasEmpty;
            if (popAcc)  void'(modelQ.pop_front());
            if (pushAcc) modelQ.push_back(d);
        end
    endtask

    // Compare every observable output with the reference model.
    task automatic checkOutput(input string tag);
        checkBit({tag, ".empty"},    bus.empty,        modelQ.size() == 0);
        checkBit({tag, ".full"},     bus.full,         modelQ.size() == 16);
        checkBit({tag, ".overrun"},  bus.overrun,      modelOvr);
        checkBit({tag, ".underrun"}, bus.underrun,     modelUnd);
        checkBit({tag, ".thre"},     bus.thre_trigger, modelQ.size() >= int'(curThr));
        if (modelQ.size() != 0) begin
            checkByte({tag, ".dout"}, bus.dout, modelQ[0]);
        end
    endtask

    initial begin
        logic [7:0] firstBytes[16];
        logic [7:0] b;
        int         pushPct;

        rst = 1'b1; bus.en = 1'b0; bus.push_in = 1'b0; bus.pop_in = 1'b0;
        bus.din = '0; bus.threshold = 4'd10; curThr = 4'd10;

        // rst en push pop din thr | empty full ovr und thre chkDout dout
        vecs[0]  = '{1, 0, 0, 0, 8'h00, 4'd10, 1, 0, 0, 0, 0, 0, 8'h00};
        vecs[1]  = '{0, 1, 0, 1, 8'h00, 4'd10, 1, 0, 0, 1, 0, 0, 8'h00};
        vecs[2]  = '{0, 1, 1, 0, 8'h11, 4'd1,  0, 0, 0, 0, 1, 1, 8'h11};
        vecs[3]  = '{0, 1, 1, 1, 8'h22, 4'd1,  0, 0, 0, 0, 1, 1, 8'h22};
        vecs[4]  = '{0, 0, 1, 0, 8'h33, 4'd1,  0, 0, 0, 0, 1, 1, 8'h22};
        vecs[5]  = '{0, 0, 0, 1, 8'h00, 4'd1,  0, 0, 0, 0, 1, 1, 8'h22};
        vecs[6]  = '{0, 1, 0, 1, 8'h00, 4'd0,  1, 0, 0, 0, 1, 0, 8'h00};
        vecs[7]  = '{0, 1, 1, 1, 8'h44, 4'd1,  0, 0, 0, 1, 1, 1, 8'h44};
        vecs[8]  = '{0, 1, 0, 0, 8'h00, 4'd2,  0, 0, 0, 0, 0, 1, 8'h44};
        vecs[9]  = '{0, 1, 1, 0, 8'h55, 4'd2,  0, 0, 0, 0, 1, 1, 8'h44};
        vecs[10] = '{1, 1, 1, 1, 8'h66, 4'd2,  1, 0, 0, 0, 0, 0, 8'h00};
        vecs[11] = '{0, 1, 1, 0, 8'h77, 4'd15, 0, 0, 0, 0, 0, 1, 8'h77};

        // Table-driven vectors.
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].en, vecs[i].push, vecs[i].pop,
                          vecs[i].din, vecs[i].thr);
            checkBit($sformatf("vec%0d.empty", i),    bus.empty,        vecs[i].eEmpty);
            checkBit($sformatf("vec%0d.full", i),     bus.full,         vecs[i].eFull);
            checkBit($sformatf("vec%0d.overrun", i),  bus.overrun,      vecs[i].eOvr);
            checkBit($sformatf("vec%0d.underrun", i), bus.underrun,     vecs[i].eUnd);
            checkBit($sformatf("vec%0d.thre", i),     bus.thre_trigger, vecs[i].eThre);
            if (vecs[i].chkDout) begin
                checkByte($sformatf("vec%0d.dout", i), bus.dout, vecs[i].eDout);
            end
        end

        // Reset held for five cycles.
        for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0, 0, 8'h00, 4'd10);
        checkBit("reset.empty",    bus.empty,        1'b1);
        checkBit("reset.full",     bus.full,         1'b0);
        checkBit("reset.overrun",  bus.overrun,      1'b0);
        checkBit("reset.underrun", bus.underrun,     1'b0);
        checkBit("reset.thre",     bus.thre_trigger, 1'b0);

        // Fill past capacity.
        for (int k = 1; k <= 20; k++) begin
            b = 8'($urandom);
            if (k <= 16) firstBytes[k-1] = b;
            applyStimulus(0, 1, 1, 0, b, 4'hA);
            checkOutput($sformatf("fill%0d", k));
            checkBit($sformatf("fill%0d.thre_k", k), bus.thre_trigger, k >= 10);
            checkBit($sformatf("fill%0d.full_k", k), bus.full,         k >= 16);
            checkBit($sformatf("fill%0d.ovr_k", k),  bus.overrun,      k > 16);
        end

        // Drain past empty.
        for (int k = 1; k <= 20; k++) begin
            if (k <= 16) checkByte($sformatf("drain%0d.head", k), bus.dout, firstBytes[k-1]);
            applyStimulus(0, 1, 0, 1, 8'h00, 4'hA);
            checkOutput($sformatf("drain%0d", k));
            checkBit($sformatf("drain%0d.empty_k", k), bus.empty,        k >= 16);
            checkBit($sformatf("drain%0d.und_k", k),   bus.underrun,     k > 16);
            checkBit($sformatf("drain%0d.thre_k", k),  bus.thre_trigger, k <= 6);
        end

        // Simultaneous push and pop at count 5.
        for (int k = 0; k < 5; k++) applyStimulus(0, 1, 1, 0, 8'($urandom), 4'd5);
        for (int k = 0; k < 6; k++) begin
            applyStimulus(0, 1, 1, 1, 8'($urandom), 4'd5);
            checkOutput($sformatf("mid%0d", k));
            checkBit($sformatf("mid%0d.at5", k), bus.thre_trigger, 1'b1);
        end
        applyStimulus(0, 1, 0, 0, 8'h00, 4'd6);
        checkBit("mid.below6", bus.thre_trigger, 1'b0);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(0, 1, 0, 1, 8'h00, 4'd5);
            checkOutput($sformatf("middrain%0d", k));
        end
        checkBit("mid.emptyAfter5", bus.empty, 1'b1);

        // Simultaneous push and pop when full.
        for (int k = 0; k < 16; k++) applyStimulus(0, 1, 1, 0, 8'($urandom), 4'd0);
        applyStimulus(0, 1, 1, 1, 8'h5A, 4'd0);
        checkOutput("fullpp");
        checkBit("fullpp.overrun", bus.overrun, 1'b0);
        checkBit("fullpp.full",    bus.full,    1'b1);
        applyStimulus(1, 0, 0, 0, 8'h00, 4'd0);

        // Simultaneous push and pop when empty.
        applyStimulus(0, 1, 1, 1, 8'hC3, 4'd0);
        checkOutput("emptypp");
        checkBit("emptypp.underrun", bus.underrun, 1'b1);
        checkByte("emptypp.dout",    bus.dout,     8'hC3);
        checkBit("emptypp.empty",    bus.empty,    1'b0);
        applyStimulus(1, 0, 0, 0, 8'h00, 4'd0);

        // Enable gating.
        for (int k = 0; k < 3; k++) applyStimulus(0, 1, 1, 0, 8'($urandom), 4'd3);
        for (int k = 0; k < 10; k++) begin
            applyStimulus(0, 0, 1'($urandom), 1'($urandom), 8'($urandom), 4'd3);
            checkOutput($sformatf("gate%0d", k));
            checkBit($sformatf("gate%0d.thre3", k), bus.thre_trigger, 1'b1);
        end
        applyStimulus(1, 0, 0, 0, 8'h00, 4'd3);

        // Wrap-around: push 12, pop 12, push 16, drain 16.
        for (int k = 0; k < 12; k++) applyStimulus(0, 1, 1, 0, 8'($urandom), 4'd8);
        for (int k = 0; k < 12; k++) applyStimulus(0, 1, 0, 1, 8'h00, 4'd8);
        for (int k = 0; k < 16; k++) applyStimulus(0, 1, 1, 0, 8'($urandom), 4'd8);
        checkBit("wrap.full", bus.full, 1'b1);
        for (int k = 0; k < 16; k++) begin
            checkOutput($sformatf("wrap%0d", k));
            applyStimulus(0, 1, 0, 1, 8'h00, 4'd8);
        end
        checkBit("wrap.empty", bus.empty, 1'b1);

        // Reset in the middle of traffic.
        for (int k = 0; k < 3; k++) applyStimulus(0, 1, 1, 0, 8'($urandom), 4'd1);
        applyStimulus(1, 1, 1, 0, 8'hEE, 4'd1);
        checkBit("midrst.empty", bus.empty, 1'b1);
        checkBit("midrst.thre",  bus.thre_trigger, 1'b0);

        // Randomized traffic against the model, alternating fill and drain bias.
        for (int i = 0; i < 1500; i++) begin
            pushPct = ((i / 100) % 2 == 0) ? 75 : 30;
            if (i % 50 == 0) curThr = 4'($urandom);
            applyStimulus($urandom_range(0, 199) == 0,
                          $urandom_range(0, 9) != 0,
                          $urandom_range(0, 99) < pushPct,
                          $urandom_range(0, 99) >= pushPct,
                          8'($urandom), curThr);
            checkOutput($sformatf("rand%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nMiscompares);
        $finish;
    end

endmodule

// File: doc/uart_fifo.md
# uart_fifo

Synchronous 16-entry × 8-bit FIFO for the UART 16550A datapath, instantiated once for TX and once for RX. It provides full/empty status and sticky-free, one-cycle overrun/underrun error pulses. It also provides a programmable fill-level trigger (`thre_trigger`) used for FIFO-threshold interrupts. Data is first-word-fall-through: the head entry is always visible on `dout`.

## Interface
- `DATA_W`, default 8: entry width.
- `DEPTH`, default 16: number of entries; must be a power of two, and `$clog2(DEPTH)` must equal the `threshold` width (4).
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `en` in 1: FIFO enable. When low, push and pop are ignored and the error pulses stay 0. Storage and flags hold.
- `push_in` in 1: write request; `din` is written at the edge.
- `pop_in` in 1: read request; the head entry is discarded at the edge.
- `din` in `DATA_W`: write data.
- `dout` out `DATA_W`: current head entry (combinational read of storage at the read pointer).
- `empty` out 1: count == 0.
- `full` out 1: count == `DEPTH`.
- `overrun` out 1: registered one-cycle pulse for a rejected push.
- `underrun` out 1: registered one-cycle pulse for a rejected pop.
- `threshold` in 4: trigger level, 0–15.
- `thre_trigger` out 1: count >= `threshold`.

## Operation
- State:
  - `mem[DEPTH]`
  - `wr_ptr` and `rd_ptr`, `$clog2(DEPTH)` bits each, wrapping naturally from 15 to 0
  - `count`, `$clog2(DEPTH)+1` bits, range 0–16
- Effective requests:
  - push_ok = `en` & `push_in` & (!`full` | `pop_in`)
  - pop_ok = `en` & `pop_in` & !`empty`
- On push_ok: `mem[wr_ptr]` <= `din`, and `wr_ptr` increments.
- On pop_ok: `rd_ptr` increments.
- `count` update:
  - +1 if push_ok only
  - −1 if pop_ok only
  - unchanged if both or neither
- Push and pop in the same cycle:
  - Not empty, not full: both happen; count unchanged.
  - Full: both happen (pop frees the slot); no overrun.
  - Empty: push only; `underrun` pulses. The pushed byte appears on `dout` next cycle.
- Rejected push: `en` & `push_in` & `full` & !`pop_in` -> `overrun` = 1 next cycle; data is dropped and pointers are unchanged.
- Rejected pop: `en` & `pop_in` & `empty` -> `underrun` = 1 next cycle; pointers are unchanged.
- Repeated violations give `overrun`/`underrun` high on each following cycle; there is no stickiness.
- `dout` when empty: the stale entry at `rd_ptr`. This is undefined to consumers, but must be a deterministic storage value.
- `thre_trigger`: combinational compare of `count` against the live `threshold`. `threshold` = 0 means it is always asserted.

## Timing
- Reset (synchronous, edge with `rst` = 1) sets:
  - `wr_ptr` = `rd_ptr` = `count` = 0
  - `empty` = 1, `full` = 0
  - `overrun` = `underrun` = 0
- `mem` is not cleared by reset.
- `rst` overrides all requests in the same cycle; reset mid-operation discards contents.
- `empty`/`full`/`count` reflect the state after the edge: zero-cycle latency from state to flags, one-cycle latency from request to flags.
- Data latency: a byte pushed into an empty FIFO at edge N is on `dout` after edge N.
- After reset, `thre_trigger` equals (0 >= `threshold`).

## Structure
- Shared package `uart_fifo_pkg`:
  - `FIFO_DEPTH` = 16
  - `FIFO_DATA_W` = 8
  - `FIFO_PTR_W` = 4
  - `FIFO_CNT_W` = 5
  - typedef `fifo_data_t` (logic [7:0])
- Optional sub-module `uart_fifo_mem`: 16×8 register array with synchronous write and asynchronous read. Control logic, counter and flags stay in `uart_fifo`.

## Test plan
- Reset: hold `rst` 5 cycles -> `empty` = 1, `full` = 0, `overrun` = `underrun` = 0; with `threshold` = 10, `thre_trigger` = 0.
- Fill past capacity: `threshold` = 0xA, 20 consecutive pushes of random bytes.
  - `thre_trigger` rises after the 10th push.
  - `full` rises after the 16th push.
  - `overrun` is high on the 4 cycles following pushes 17–20.
  - Contents remain the first 16 bytes.
- Drain past empty: then 20 consecutive pops.
  - `dout` presents the first 16 bytes in order.
  - `thre_trigger` falls when count drops to 9.
  - `empty` rises after the 16th pop.
  - `underrun` is high for the 4 following cycles.
- Simultaneous push and pop:
  - At count 5: count stays 5 and order is preserved.
  - At full: no overrun, `full` stays 1.
  - At empty: `underrun` pulses and `dout` equals the pushed byte next cycle.
- Enable gating: `en` = 0 with push/pop toggling -> count, pointers and flags unchanged; no error pulses.
- Wrap-around and mid-reset:
  - Push 12, pop 12, push 16 -> `full` = 1 and correct order across the pointer wrap.
  - Assert `rst` mid-stream -> `empty` = 1 next cycle.
